// File: rtl/multi_mips_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcodes, ALUOp codes, Funct codes, ALUControl codes, mux select codes
// and the packed control word the FSM drives each cycle.
package multi_mips_controller_pkg;

  // FSM state encodings; the numeric values are visible on the debug port.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11
  } state_e;

  // Opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes from the FSM to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Funct codes (instr[5:0]) for R-type instructions.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl codes seen by the datapath ALU.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B select.
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Everything the FSM decides in one state; all-zero means "do nothing".
  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dst;
    logic       iord;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multi_mips_controller_if.sv
// Signal bundle between the multicycle datapath and its control unit.
// There is no valid/ready handshake here: the controller is a per-cycle
// sideband. Instruction fields and Zero are inputs that are meaningful every
// cycle; every output is valid every cycle and reflects the current state
// (plus Funct for ALUControl and Zero for PCEn).
interface multi_mips_controller_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemToReg;
  logic       RegDst;
  logic       IorD;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IRWrite;
  logic       MemWrite;
  logic       PCWrite;
  logic       Branch;
  logic       RegWrite;
  logic [2:0] ALUControl;

  // Datapath side: supplies instruction fields and Zero, consumes controls.
  modport master (
    output Opcode, Funct, Zero,
    input  MemToReg, RegDst, IorD, PCSrc, PCEn, ALUSrcA, ALUSrcB,
           IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUControl
  );

  // Controller side.
  modport slave (
    input  Opcode, Funct, Zero,
    output MemToReg, RegDst, IorD, PCSrc, PCEn, ALUSrcA, ALUSrcB,
           IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUControl
  );
endinterface

// File: rtl/multi_mips_aludec.sv
// ALU decoder: maps the FSM's ALUOp plus the instruction Funct field onto
// the 3-bit ALUControl. Purely combinational. Funct only matters for
// ALUOp = 10; unknown Funct values and ALUOp = 11 fall back to add.
module multi_mips_aludec
  import multi_mips_controller_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  // Select the ALU operation from ALUOp, consulting Funct for R-type.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_mips_controller.sv
// Control unit for the multicycle MIPS datapath: a Moore FSM sequencing
// FETCH/DECODE/execute steps from Opcode, an ALU decoder, and the PCEn gate
// (PCWrite | (Branch & Zero)). The current state is exported on state_o.
// Build option: define CTRL_JUMP_EN to add the JUMP state for opcode 000010;
// without it, 000010 is an unsupported opcode and PCSrc=10 is never driven.
module multi_mips_controller
  import multi_mips_controller_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  multi_mips_controller_if.slave   ctrl_if,
  output logic [3:0]               state_o
);

`ifdef CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  state_e     state_q;
  state_e     state_d;
  ctrl_t      cw;
  logic [2:0] alu_control;

  // State register; reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore control word; anything not set in a state stays 0.
  always_comb begin
    state_d = ST_FETCH;
    cw      = '0;
    case (state_q)
      ST_FETCH: begin
        cw.alu_src_b = SRCB_FOUR;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        cw.alu_src_b = SRCB_IMMSH;
        case (ctrl_if.Opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = JUMP_EN ? ST_JUMP : ST_FETCH;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        state_d      = (ctrl_if.Opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        cw.iord = 1'b1;
        state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEMWR: begin
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_FUNCT;
        state_d      = ST_ALUWB;
      end
      ST_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_SUB;
        cw.branch    = 1'b1;
        cw.pc_src    = PCSRC_ALUOUT;
        state_d      = ST_FETCH;
      end
      ST_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
        state_d      = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        cw.reg_write = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_JUMP: begin
        // Only reachable when the jump option is built in.
        if (JUMP_EN) begin
          cw.pc_src   = PCSRC_JUMP;
          cw.pc_write = 1'b1;
        end
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  multi_mips_aludec u_aludec (
    .alu_op_i      (cw.alu_op),
    .funct_i       (ctrl_if.Funct),
    .alu_control_o (alu_control)
  );

  // Drive the datapath controls; PCEn folds in the taken-branch condition.
  always_comb begin
    ctrl_if.MemToReg   = cw.mem_to_reg;
    ctrl_if.RegDst     = cw.reg_dst;
    ctrl_if.IorD       = cw.iord;
    ctrl_if.PCSrc      = cw.pc_src;
    ctrl_if.ALUSrcA    = cw.alu_src_a;
    ctrl_if.ALUSrcB    = cw.alu_src_b;
    ctrl_if.IRWrite    = cw.ir_write;
    ctrl_if.MemWrite   = cw.mem_write;
    ctrl_if.PCWrite    = cw.pc_write;
    ctrl_if.Branch     = cw.branch;
    ctrl_if.RegWrite   = cw.reg_write;
    ctrl_if.ALUControl = alu_control;
    ctrl_if.PCEn       = cw.pc_write | (cw.branch & ctrl_if.Zero);
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multi_mips_controller.sv
// Bench for multi_mips_controller: randomized instruction stream with
// occasional mid-instruction resets; expected per-cycle control vectors come
// from an instruction-level step table and are checked by a monitor.
module tb_multi_mips_controller;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [3:0] state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multi_mips_controller_if bus ();

  multi_mips_controller dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus),
    .state_o (state)
  );

  // Expected vector layout:
  // {state[3:0], MemToReg, RegDst, IorD, PCSrc[1:0], PCEn, ALUSrcA,
  //  ALUSrcB[1:0], IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUControl[2:0]}
  localparam int W = 21;
  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // ---------------- reference model ----------------
  // R-type operation selected by the Funct field.
  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one step of an instruction.
  function automatic logic [W-1:0] model(input int st, input logic [5:0] fn, input logic z);
    logic m2r, rdst, iord, asa, irw, mw, pcw, br, rw;
    logic [1:0] pcs, asb, aluop;
    logic [2:0] ac;
    logic pcen;
    m2r = 0; rdst = 0; iord = 0; asa = 0; irw = 0; mw = 0; pcw = 0; br = 0; rw = 0;
    pcs = 2'b00; asb = 2'b00; aluop = 2'b00;
    case (st)
      0:  begin asb = 2'b01; irw = 1; pcw = 1; end
      1:  begin asb = 2'b11; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aluop = 2'b01; br = 1; pcs = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin rw = 1; end
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (aluop == 2'b01)      ac = 3'b110;
    else if (aluop == 2'b10) ac = r_alu(fn);
    else                     ac = 3'b010;
    pcen = pcw | (br & z);
    return {4'(st), m2r, rdst, iord, pcs, pcen, asa, asb, irw, mw, pcw, br, rw, ac};
  endfunction

  // ---------------- driver ----------------
  // Runs one instruction step by step; abort_at >= 0 asserts reset during
  // that step so the next instruction starts from FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
    int seq[$];
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = JUMP_EN ? '{0, 1, 11} : '{0, 1};
      default:   seq = '{0, 1};
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      // Opcode only matters in DECODE/MEMADR; elsewhere it is scrambled.
      bus.Opcode = (seq[k] == 1 || seq[k] == 2) ? op : 6'($urandom);
      bus.Funct  = (seq[k] == 6) ? fn : 6'($urandom);
      bus.Zero   = 1'($urandom);
      reset      = (k == abort_at);
      exp_q.push_back(model(seq[k], bus.Funct, bus.Zero));
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state, bus.MemToReg, bus.RegDst, bus.IorD, bus.PCSrc, bus.PCEn,
               bus.ALUSrcA, bus.ALUSrcB, bus.IRWrite, bus.MemWrite, bus.PCWrite,
               bus.Branch, bus.RegWrite, bus.ALUControl};
      total_cnt++;
      if (act_v === exp_v) pass_cnt++;
      else $display("FAIL ctrl_vec t=%0t actual=%06h required=%06h", $time, act_v, exp_v);
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] dir_op[7] = '{6'b100011, 6'b000000, 6'b000000, 6'b000100,
                            6'b101011, 6'b111111, 6'b000010};
  logic [5:0] dir_fn[7] = '{6'b000000, 6'b100000, 6'b101010, 6'b000000,
                            6'b000000, 6'b000000, 6'b000000};
  logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] op_tab[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b001000, 6'b000010, 6'b111111};

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         ab;
    int         sel;
    reset      = 1'b1;
    bus.Opcode = 6'b0;
    bus.Funct  = 6'b0;
    bus.Zero   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed pass over the named instruction classes.
    for (int i = 0; i < 7; i++) run_instr(dir_op[i], dir_fn[i], -1);

    // Randomized stream with occasional resets from arbitrary steps.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      op  = (sel == 7) ? 6'($urandom) : op_tab[sel];
      sel = $urandom_range(0, 5);
      fn  = (sel == 5) ? 6'($urandom) : fn_tab[sel];
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, fn, ab);
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    if (total_cnt < 12) begin
      total_cnt++;
      $display("FAIL check_count actual=%0d required>=12", total_cnt);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
